ob_rsp_serializer: RTL and testbench

//  Transmit side of the OB response path: accepts one ob_pkg::rsp_t per

---
 rtl/ob_rsp_serializer_pkg.sv | 37 +++
 rtl/ob_rsp_serializer_if.sv | 27 ++
 rtl/ob_rsp_serializer.sv | 94 +++++++++
 tb/tb_ob_rsp_serializer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_rsp_serializer_pkg.sv
// Shared types for the OB response path.
// Response bundle, status codes and frame header layout.
package ob_rsp_serializer_pkg;

  typedef enum logic [2:0] {
    S_Okay     = 3'd0,
    S_Reject   = 3'd1,
    S_Cancel   = 3'd2,
    S_NotFound = 3'd3,
    S_Full     = 3'd4,
    S_BadPop   = 3'd5
  } status_t;

  typedef struct packed {
    logic [31:0] uid;
    status_t     status;
    logic [79:0] result;
  } rsp_t;

  typedef struct packed {
    logic [3:0] sof;
    logic       rsvd;
    status_t    status;
  } rsp_frame_hdr_t;

  localparam int unsigned RSP_FRAME_LONG_N  = 15;
  localparam int unsigned RSP_FRAME_SHORT_N = 5;

  // The result field travels only with a good status unless forced on.
  function automatic logic rsp_is_long(
    input status_t s,
    input logic    roe
  );
    return roe | (s == S_Okay);
  endfunction

endpackage

// File: rtl/ob_rsp_serializer_if.sv
// Engine response port plus egress byte link.
// master drives responses and byte backpressure; slave is the serializer.
interface ob_rsp_serializer_if;
  import ob_rsp_serializer_pkg::*;

  logic       rsp_vld;
  rsp_t       rsp;
  logic       rsp_accept;
  logic       out_vld;
  logic [7:0] out_byte;
  logic       out_sop;
  logic       out_eop;
  logic       out_rdy;

  modport master (
    output rsp_vld, rsp, out_rdy,
    input  rsp_accept, out_vld,
    input  out_byte, out_sop, out_eop
  );

  modport slave (
    input  rsp_vld, rsp, out_rdy,
    output rsp_accept, out_vld,
    output out_byte, out_sop, out_eop
  );

endinterface

// File: rtl/ob_rsp_serializer.sv
// OB response serializer: one rsp_t in, one byte frame out.
// Header + uid always, result only in long frames; 1 byte/clk.
module ob_rsp_serializer
  import ob_rsp_serializer_pkg::*;
#(
  parameter logic [3:0] SOF_NIBBLE      = 4'hA,
  parameter bit         RESULT_ON_ERROR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  ob_rsp_serializer_if.slave   bus
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [3:0] LAST_LONG  = 4'(RSP_FRAME_LONG_N - 1);
  localparam logic [3:0] LAST_SHORT = 4'(RSP_FRAME_SHORT_N - 1);

  state_t         state_q;
  state_t         state_d;
  logic [119:0]   sr_q;
  logic [3:0]     idx_q;
  logic           long_q;

  logic           busy;
  logic           sop;
  logic           eop;
  logic           hs;
  logic           accept;
  logic           load;
  logic [3:0]     last_idx;
  rsp_frame_hdr_t hdr;
  logic [119:0]   frame;

  assign busy     = (state_q == SEND);
  assign last_idx = long_q ? LAST_LONG : LAST_SHORT;
  assign sop      = busy & (idx_q == 4'd0);
  assign eop      = busy & (idx_q == last_idx);
  assign hs       = busy & bus.out_rdy;

  assign hdr.sof    = SOF_NIBBLE;
  assign hdr.rsvd   = 1'b0;
  assign hdr.status = bus.rsp.status;

  assign frame = {hdr, bus.rsp.uid, bus.rsp.result};

  // Next state plus accept/load; accept never looks at rsp_vld.
  always_comb begin
    state_d = state_q;
    accept  = ~busy | (hs & eop);
    load    = bus.rsp_vld & accept;
    unique case (state_q)
      IDLE: begin
        if (load) state_d = SEND;
      end
      SEND: begin
        if (hs & eop & ~bus.rsp_vld) state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any partial frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Shift register, byte index and frame length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      idx_q  <= '0;
      long_q <= 1'b0;
    end else if (load) begin
      sr_q   <= frame;
      idx_q  <= '0;
      long_q <= rsp_is_long(bus.rsp.status,
                            RESULT_ON_ERROR);
    end else if (hs) begin
      sr_q  <= {sr_q[111:0], 8'h00};
      idx_q <= eop ? 4'd0 : idx_q + 4'd1;
    end
  end

  assign bus.rsp_accept = accept;
  assign bus.out_vld    = busy;
  assign bus.out_byte   = sr_q[119:112];
  assign bus.out_sop    = sop;
  assign bus.out_eop    = eop;

endmodule

// File: tb/tb_ob_rsp_serializer.sv
// Bench for ob_rsp_serializer: directed frames plus random scoreboard.
// Two instances differ only in RESULT_ON_ERROR; sel picks the observed one.
module tb_ob_rsp_serializer;
  import ob_rsp_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ob_rsp_serializer_if if0 ();
  ob_rsp_serializer_if if1 ();

  ob_rsp_serializer #(
    .SOF_NIBBLE      (4'hA),
    .RESULT_ON_ERROR (1'b0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  ob_rsp_serializer #(
    .SOF_NIBBLE      (4'hA),
    .RESULT_ON_ERROR (1'b1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  logic       rsp_vld;
  rsp_t       rsp;
  logic       out_rdy;
  logic       sel;

  assign if0.rsp_vld = rsp_vld;
  assign if0.rsp     = rsp;
  assign if0.out_rdy = out_rdy;
  assign if1.rsp_vld = rsp_vld;
  assign if1.rsp     = rsp;
  assign if1.out_rdy = out_rdy;

  logic       o_acc;
  logic       o_vld;
  logic [7:0] o_byte;
  logic       o_sop;
  logic       o_eop;

  assign o_acc  = sel ? if1.rsp_accept : if0.rsp_accept;
  assign o_vld  = sel ? if1.out_vld    : if0.out_vld;
  assign o_byte = sel ? if1.out_byte   : if0.out_byte;
  assign o_sop  = sel ? if1.out_sop    : if0.out_sop;
  assign o_eop  = sel ? if1.out_eop    : if0.out_eop;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame length and byte k from the frame rules.
  function automatic int frame_len(input logic [2:0] st,
                                   input bit roe);
    return (roe || st == 3'd0) ? 15 : 5;
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic [2:0]  st,
    input logic [31:0] uid,
    input logic [79:0] res,
    input int          k
  );
    if (k == 0) return {4'hA, 1'b0, st};
    if (k < 5)  return 8'(uid >> (8 * (4 - k)));
    return 8'(res >> (8 * (14 - k)));
  endfunction

  function automatic rsp_t rand_rsp();
    rsp_t r;
    r.uid    = $urandom;
    r.status = status_t'(3'($urandom_range(0, 7)));
    r.result = {$urandom, $urandom, 16'($urandom)};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    rsp_vld = 1'b0;
    out_rdy = 1'b0;
    rsp     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame_check(input rsp_t r,
                                  input bit roe,
                                  input string tag);
    int n;
    logic [10:0] exp;
    n = frame_len(r.status, roe);
    @(negedge clk);
    rsp_vld = 1'b1;
    rsp     = r;
    out_rdy = 1'b1;
    #1;
    n_cmp++;
    if (o_acc !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_accept: got %b want 1", tag, o_acc);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rsp_vld = 1'b0;
      #1;
      exp = {1'b1, k == 0, k == n - 1,
             frame_byte(r.status, r.uid, r.result, k)};
      n_cmp++;
      if ({o_vld, o_sop, o_eop, o_byte} !== exp) begin
        n_bad++;
        $display("FAIL %s_byte%0d: got %h want %h", tag, k,
                 {o_vld, o_sop, o_eop, o_byte}, exp);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: out_vld got %b want 0", tag, o_vld);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst     = 1'b1;
    rsp_vld = 1'b0;
    out_rdy = 1'b0;
    rsp     = '0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_cmp++;
      if ({o_vld, o_sop, o_eop, o_byte} !== 11'h0) begin
        n_bad++;
        $display("FAIL reset_out%0d: got %h want 000", s,
                 {o_vld, o_sop, o_eop, o_byte});
      end
      n_cmp++;
      if (o_acc !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_acc%0d: got %b want 1", s, o_acc);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_okay_frame();
    logic [7:0] lit [15];
    rsp_t r;
    lit = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h00, 8'h00, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h07,
            8'h00, 8'h64};
    do_reset();
    sel      = 1'b0;
    r.uid    = 32'h0000_0001;
    r.status = S_Okay;
    r.result = {32'd5, 32'd7, 16'd100};
    @(negedge clk);
    rsp_vld = 1'b1;
    rsp     = r;
    out_rdy = 1'b1;
    #1;
    n_cmp++;
    if (o_acc !== 1'b1) begin
      n_bad++;
      $display("FAIL okay_accept: got %b want 1", o_acc);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      rsp_vld = 1'b0;
      #1;
      n_cmp++;
      if ({o_vld, o_sop, o_eop, o_byte} !==
          {1'b1, k == 0, k == 14, lit[k]}) begin
        n_bad++;
        $display("FAIL okay_byte%0d: got %h want %h", k,
                 {o_vld, o_sop, o_eop, o_byte},
                 {1'b1, k == 0, k == 14, lit[k]});
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL okay_idle: got %b want 0", o_vld);
    end
  endtask

  task automatic test_reject();
    rsp_t r;
    r.uid    = 32'hDEAD_BEEF;
    r.status = S_Reject;
    r.result = {32'h1122_3344, 32'h5566_7788, 16'h99AA};
    do_reset();
    sel = 1'b0;
    send_frame_check(r, 1'b0, "reject_short");
    do_reset();
    sel = 1'b1;
    send_frame_check(r, 1'b1, "reject_long");
    for (int s = 6; s < 8; s++) begin
      r        = rand_rsp();
      r.status = status_t'(3'(s));
      do_reset();
      sel = 1'b0;
      send_frame_check(r, 1'b0, "undef_short");
      do_reset();
      sel = 1'b1;
      send_frame_check(r, 1'b1, "undef_long");
    end
  endtask

  task automatic test_back_to_back();
    rsp_t       rs [4];
    logic [7:0] stream [$];
    int         nxt;
    logic       exp_acc;
    logic [10:0] exp;
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs[i]        = rand_rsp();
      rs[i].status = S_Reject;
      for (int k = 0; k < 5; k++)
        stream.push_back(frame_byte(rs[i].status, rs[i].uid,
                                    rs[i].result, k));
    end
    nxt = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      rsp_vld = (nxt < 4);
      rsp     = rs[nxt < 4 ? nxt : 3];
      out_rdy = 1'b1;
      #1;
      exp_acc = (c == 0) || (c % 5 == 0);
      n_cmp++;
      if (o_acc !== exp_acc) begin
        n_bad++;
        $display("FAIL b2b_acc_c%0d: got %b want %b", c,
                 o_acc, exp_acc);
      end
      if (c >= 1) begin
        exp = {1'b1, (c - 1) % 5 == 0, (c - 1) % 5 == 4,
               stream[c - 1]};
        n_cmp++;
        if ({o_vld, o_sop, o_eop, o_byte} !== exp) begin
          n_bad++;
          $display("FAIL b2b_byte%0d: got %h want %h", c - 1,
                   {o_vld, o_sop, o_eop, o_byte}, exp);
        end
      end
      if (rsp_vld && o_acc) nxt++;
    end
    @(negedge clk);
    rsp_vld = 1'b0;
    #1;
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got %b want 0", o_vld);
    end
  endtask

  task automatic test_random();
    logic [7:0] qb [$];
    bit         qs [$];
    bit         qe [$];
    int         sent;
    int         frames;
    int         cyc;
    bit         last_acc;
    bit         exp_busy;
    bit         exp_acc;
    bit         hs;
    bit         prev_stall;
    logic [9:0] prev;
    rsp_t       r;
    int         n;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      sel        = s[0];
      sent       = 0;
      frames     = 0;
      cyc        = 0;
      last_acc   = 1'b0;
      prev_stall = 1'b0;
      prev       = '0;
      while ((sent < 500 || qb.size() != 0) && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        if (!(rsp_vld && !last_acc)) begin
          rsp_vld = (sent < 500) && ($urandom_range(0, 3) != 0);
          rsp     = rand_rsp();
        end
        out_rdy = $urandom_range(0, 1) == 1;
        #1;
        exp_busy = (qb.size() != 0);
        hs       = exp_busy && out_rdy;
        exp_acc  = !exp_busy || (hs && qe[0]);
        n_cmp++;
        if (o_acc !== exp_acc) begin
          n_bad++;
          $display("FAIL rnd_acc_cyc%0d: got %b want %b", cyc,
                   o_acc, exp_acc);
        end
        n_cmp++;
        if (o_vld !== exp_busy) begin
          n_bad++;
          $display("FAIL rnd_vld_cyc%0d: got %b want %b", cyc,
                   o_vld, exp_busy);
        end
        if (prev_stall) begin
          n_cmp++;
          if ({o_sop, o_eop, o_byte} !== prev) begin
            n_bad++;
            $display("FAIL rnd_stall_cyc%0d: got %h want %h", cyc,
                     {o_sop, o_eop, o_byte}, prev);
          end
        end
        if (exp_busy) begin
          n_cmp++;
          if ({o_sop, o_eop, o_byte} !== {qs[0], qe[0], qb[0]}) begin
            n_bad++;
            $display("FAIL rnd_byte_cyc%0d: got %h want %h", cyc,
                     {o_sop, o_eop, o_byte},
                     {qs[0], qe[0], qb[0]});
          end
        end
        prev_stall = exp_busy && !out_rdy;
        prev       = {o_sop, o_eop, o_byte};
        if (hs) begin
          if (qe[0]) frames++;
          void'(qb.pop_front());
          void'(qs.pop_front());
          void'(qe.pop_front());
        end
        last_acc = rsp_vld && exp_acc;
        if (last_acc) begin
          r = rsp;
          n = frame_len(r.status, s[0]);
          for (int k = 0; k < n; k++) begin
            qb.push_back(frame_byte(r.status, r.uid, r.result, k));
            qs.push_back(k == 0);
            qe.push_back(k == n - 1);
          end
          sent++;
        end
      end
      rsp_vld = 1'b0;
      n_cmp++;
      if (frames !== 500) begin
        n_bad++;
        $display("FAIL rnd_frames%0d: got %0d want 500 (cyc %0d)",
                 s, frames, cyc);
      end
      qb.delete();
      qs.delete();
      qe.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    rsp_t r;
    do_reset();
    sel      = 1'b0;
    r        = rand_rsp();
    r.status = S_Okay;
    @(negedge clk);
    rsp_vld = 1'b1;
    rsp     = r;
    out_rdy = 1'b1;
    repeat (8) begin
      @(negedge clk);
      rsp_vld = 1'b0;
    end
    #1;
    n_cmp++;
    if ({o_vld, o_byte} !==
        {1'b1, frame_byte(r.status, r.uid, r.result, 7)}) begin
      n_bad++;
      $display("FAIL mid_byte7: got %h want %h", {o_vld, o_byte},
               {1'b1, frame_byte(r.status, r.uid, r.result, 7)});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_vld, o_sop, o_eop} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_rst_vld: got %b want 000",
               {o_vld, o_sop, o_eop});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_after_rel: got %b want 0", o_vld);
    end
    r        = rand_rsp();
    r.status = S_Reject;
    send_frame_check(r, 1'b0, "mid_fresh");
  endtask

  task automatic test_stall_badpop();
    rsp_t r;
    do_reset();
    sel      = 1'b0;
    r        = rand_rsp();
    r.uid    = 32'h0;
    r.status = S_BadPop;
    @(negedge clk);
    rsp_vld = 1'b1;
    rsp     = r;
    out_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rsp_vld = 1'b1;
      rsp     = rand_rsp();
      out_rdy = 1'b0;
      #1;
      n_cmp++;
      if ({o_acc, o_vld, o_sop, o_eop, o_byte} !==
          {1'b0, 1'b1, 1'b1, 1'b0, 8'hA5}) begin
        n_bad++;
        $display("FAIL stall_c%0d: got %h want %h", c,
                 {o_acc, o_vld, o_sop, o_eop, o_byte},
                 {1'b0, 1'b1, 1'b1, 1'b0, 8'hA5});
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rsp_vld = 1'b0;
      out_rdy = 1'b1;
      #1;
      n_cmp++;
      if ({o_vld, o_sop, o_eop, o_byte} !==
          {1'b1, k == 0, k == 4,
           frame_byte(r.status, r.uid, r.result, k)}) begin
        n_bad++;
        $display("FAIL stall_drain%0d: got %h want %h", k,
                 {o_vld, o_sop, o_eop, o_byte},
                 {1'b1, k == 0, k == 4,
                  frame_byte(r.status, r.uid, r.result, k)});
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    rsp_vld = 1'b0;
    out_rdy = 1'b0;
    rsp     = '0;
    sel     = 1'b0;
    test_reset();
    test_okay_frame();
    test_reject();
    test_back_to_back();
    test_stall_badpop();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
